sysid_read_arbiter: RTL and testbench
=====================================

# sysid_read_arbiter

Shares the single-word-addressed system ID control slave between two Avalon-MM read masters (CPU data master and debug/JTAG master). Arbitrates per cycle, drives the slave's address, registers the returned word and presents it to the winning master one cycle later with `readdatavalid`. Sits between the interconnect masters and the sysid slave, in the same clock domain.

## Interface
- `DATA_WIDTH`, 32, width of sysid readdata and master readdata.
- `ADDR_WIDTH`, 1, slave word address width (word 0 = system ID, word 1 = timestamp).

- `clock`  in  1  system clock, all logic rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `m0_read`  in  1  master 0 read request; held with address while `m0_waitrequest`=1.
- `m0_address`  in  ADDR_WIDTH  master 0 word address.
- `m0_waitrequest`  out  1  master 0 stall.
- `m0_readdata`  out  DATA_WIDTH  master 0 returned data.
- `m0_readdatavalid`  out  1  master 0 data strobe, one cycle per accepted read.
- `m1_read`, `m1_address`, `m1_waitrequest`, `m1_readdata`, `m1_readdatavalid`: same as master 0, for master 1.
- `s_address`  out  ADDR_WIDTH  address to sysid slave.
- `s_readdata`  in  DATA_WIDTH  combinational data from sysid slave.

## Operation
- Registers: `last_grant` (1 bit), `rdata_q` (DATA_WIDTH), `rvalid0_q`, `rvalid1_q`.
- Grant (combinational, same cycle): only m0 requesting -> grant 0; only m1 -> grant 1; both -> master not equal to `last_grant` (round robin); none -> no grant.
- `mX_waitrequest` = `mX_read` AND NOT grantX. Waitrequest is 0 when not reading.
- Accept: a read is accepted on the edge where `mX_read`=1 and `mX_waitrequest`=0.
- `s_address` = granted master's address; 0 when no grant.
- On accept: `rdata_q` <= `s_readdata`; `rvalidX_q` <= 1 for the winner, 0 for the other; `last_grant` <= winner. No accept: both `rvalid*_q` <= 0, `rdata_q` and `last_grant` hold.
- `mX_readdata` = `rdata_q` for both masters; valid only while own `mX_readdatavalid`=1.
- `mX_readdatavalid` = `rvalidX_q`; never both 1 in one cycle.
- Masters may issue back-to-back reads; one read accepted per cycle total.
- Address changes while stalled are protocol violations. Data is sampled only at accept.

## Timing
- Reset values: `last_grant`=1 (master 0 wins the first contention), `rdata_q`=0, `rvalid0_q`=`rvalid1_q`=0. So all `readdatavalid`=0 and `readdata`=0. Waitrequest follows inputs combinationally during reset, but no read is accepted while `reset_n`=0.
- Read latency: fixed 1 cycle from accept edge to `readdatavalid` high for exactly one cycle.
- Throughput: 1 read/cycle. Under continuous contention, grants alternate 0,1,0,1.
- Contended loser: stalled exactly 1 cycle per contention in round-robin mode.
- Reset mid-operation: asynchronous clear of all registers. A read accepted in the cycle before reset assertion returns no data. Masters reissue after release.
- Reset deassertion: first accept possible on the first rising edge with `reset_n`=1.

## Configuration
- `SYSID_ARB_ROUND_ROBIN_EN` defined: round-robin grant as above.
- Not defined: fixed priority, master 0 always wins contention. `last_grant` is not implemented. Master 1 is stalled for as long as `m0_read`=1.

## Test plan
- Reset, then m0 reads address 0 with `s_readdata`=0x5A8C_DF3F -> `m0_waitrequest`=0. Next cycle `m0_readdatavalid`=1 and `m0_readdata`=0x5A8C_DF3F. `m1_readdatavalid` stays 0.
- m1 reads address 1, then address 0 back-to-back; slave returns 0x0000_0001 then 0x5A8C_DF3F -> two consecutive valid cycles with those values, no stall.
- Both request every cycle for 6 cycles after reset -> grant order 0,1,0,1,0,1 with `readdatavalid` alternating. With the macro undefined -> m0 granted all 6 and `m1_waitrequest`=1 throughout.
- Stalled m1 holds address 1 while m0 is granted -> `s_address`=m0 address during stall. When m1 is granted, `s_address`=1 and m1 receives the address-1 word.
- Assert `reset_n`=0 asynchronously in the cycle after an accept -> `readdatavalid` drops immediately with no data delivered. After release, the first contention is granted to m0.
- Idle for 10 cycles -> `s_address`=0, both waitrequests 0, both readdatavalids 0, and `rdata_q` holds its last value.

Source files
------------

// File: rtl/sysid_read_arbiter.sv
// Two-master read arbiter in front of the single-word-addressed sysid slave.
// Define SYSID_ARB_ROUND_ROBIN_EN for round-robin grant; otherwise master 0 has fixed priority.
module sysid_read_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  m0_read,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  output logic                  m0_waitrequest,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic                  m1_read,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  output logic                  m1_waitrequest,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_WIDTH-1:0] s_address,
  input  logic [DATA_WIDTH-1:0] s_readdata
);

  logic                  grant0;
  logic                  grant1;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid0_q;
  logic                  rvalid1_q;

`ifdef SYSID_ARB_ROUND_ROBIN_EN
  // last_grant resets to 1 so master 0 wins the first contention.
  logic last_grant;

  always_comb begin
    grant0 = m0_read && (!m1_read || last_grant);
    grant1 = m1_read && (!m0_read || !last_grant);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant1;
    end
  end
`else
  always_comb begin
    grant0 = m0_read;
    grant1 = m1_read && !m0_read;
  end
`endif

  always_comb begin
    accept         = grant0 || grant1;
    m0_waitrequest = m0_read && !grant0;
    m1_waitrequest = m1_read && !grant1;
    s_address      = '0;
    if (grant0) begin
      s_address = m0_address;
    end else if (grant1) begin
      s_address = m1_address;
    end
  end

  // Slave data is captured only on an accepting edge and held otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= grant0;
      rvalid1_q <= grant1;
      if (accept) begin
        rdata_q <= s_readdata;
      end
    end
  end

  assign m0_readdata      = rdata_q;
  assign m1_readdata      = rdata_q;
  assign m0_readdatavalid = rvalid0_q;
  assign m1_readdatavalid = rvalid1_q;

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Directed self-checking bench for sysid_read_arbiter; expectations follow SYSID_ARB_ROUND_ROBIN_EN.
module tb_sysid_read_arbiter;

  localparam int DW = 32;
  localparam int AW = 1;
  localparam logic [DW-1:0] ID_WORD = 32'h5A8C_DF3F;
  localparam logic [DW-1:0] TS_WORD = 32'h0000_0001;

`ifdef SYSID_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          m0_read = 1'b0;
  logic [AW-1:0] m0_address = '0;
  logic          m0_waitrequest;
  logic [DW-1:0] m0_readdata;
  logic          m0_readdatavalid;
  logic          m1_read = 1'b0;
  logic [AW-1:0] m1_address = '0;
  logic          m1_waitrequest;
  logic [DW-1:0] m1_readdata;
  logic          m1_readdatavalid;
  logic [AW-1:0] s_address;
  logic [DW-1:0] s_readdata;

  int checks = 0;
  int failures = 0;

  // Sysid slave: word 0 = system ID, word 1 = timestamp.
  assign s_readdata = (s_address == 1'b1) ? TS_WORD : ID_WORD;

  always #5 clock = ~clock;

  sysid_read_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .m0_read(m0_read),
    .m0_address(m0_address),
    .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_read(m1_read),
    .m1_address(m1_address),
    .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address),
    .s_readdata(s_readdata)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    m0_read = 1'b0;
    m1_read = 1'b0;
    reset_n = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m0_read = 1'b1;
    m0_address = 1'b0;
    cycle();
    checks++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b%b exp=00", m0_readdatavalid, m1_readdatavalid);
    end
    checks++;
    if (m0_readdata !== '0 || m1_readdata !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h exp=0", m0_readdata, m1_readdata);
    end
    checks++;
    if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b0) begin
      failures++;
      $display("FAIL reset_wait got=%b%b exp=00", m0_waitrequest, m1_waitrequest);
    end
    m0_read = 1'b0;
    #1;
    reset_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    m0_read = 1'b1;
    m0_address = 1'b0;
    #1;
    checks++;
    if (m0_waitrequest !== 1'b0 || s_address !== 1'b0) begin
      failures++;
      $display("FAIL single_grant wait=%b s_addr=%b exp wait=0 s_addr=0", m0_waitrequest, s_address);
    end
    cycle();
    m0_read = 1'b0;
    checks++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== ID_WORD) begin
      failures++;
      $display("FAIL single_data valid=%b data=%h exp valid=1 data=%h", m0_readdatavalid, m0_readdata, ID_WORD);
    end
    checks++;
    if (m1_readdatavalid !== 1'b0) begin
      failures++;
      $display("FAIL single_m1_valid got=%b exp=0", m1_readdatavalid);
    end
    cycle();
    checks++;
    if (m0_readdatavalid !== 1'b0) begin
      failures++;
      $display("FAIL single_one_strobe got=%b exp=0", m0_readdatavalid);
    end
    $display("test_single_read done");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_data [2];
    exp_data[0] = TS_WORD;
    exp_data[1] = ID_WORD;
    m1_read = 1'b1;
    m1_address = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (m1_waitrequest !== 1'b0 || s_address !== m1_address) begin
        failures++;
        $display("FAIL b2b_grant[%0d] wait=%b s_addr=%b exp wait=0 s_addr=%b", i, m1_waitrequest, s_address, m1_address);
      end
      cycle();
      if (i == 0) m1_address = 1'b0;
      else m1_read = 1'b0;
      checks++;
      if (m1_readdatavalid !== 1'b1 || m1_readdata !== exp_data[i] || m0_readdatavalid !== 1'b0) begin
        failures++;
        $display("FAIL b2b_data[%0d] v1=%b v0=%b data=%h exp v1=1 v0=0 data=%h", i, m1_readdatavalid, m0_readdatavalid, m1_readdata, exp_data[i]);
      end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_contention();
    logic g;
    do_reset();
    m0_read = 1'b1;
    m0_address = 1'b0;
    m1_read = 1'b1;
    m1_address = 1'b1;
    for (int i = 0; i < 6; i++) begin
      g = RR ? i[0] : 1'b0;
      #1;
      checks++;
      if (m0_waitrequest !== g || m1_waitrequest !== !g || s_address !== g) begin
        failures++;
        $display("FAIL contend_grant[%0d] w0=%b w1=%b s_addr=%b exp w0=%b w1=%b s_addr=%b", i, m0_waitrequest, m1_waitrequest, s_address, g, !g, g);
      end
      cycle();
      checks++;
      if (m0_readdatavalid !== !g || m1_readdatavalid !== g || m0_readdata !== (g ? TS_WORD : ID_WORD)) begin
        failures++;
        $display("FAIL contend_data[%0d] v0=%b v1=%b data=%h exp v0=%b v1=%b data=%h", i, m0_readdatavalid, m1_readdatavalid, m0_readdata, !g, g, g ? TS_WORD : ID_WORD);
      end
    end
    m0_read = 1'b0;
    m1_read = 1'b0;
    $display("test_contention done");
  endtask

  task automatic test_stalled_address();
    do_reset();
    m0_read = 1'b1;
    m0_address = 1'b0;
    m1_read = 1'b1;
    m1_address = 1'b1;
    #1;
    checks++;
    if (m1_waitrequest !== 1'b1 || m0_waitrequest !== 1'b0 || s_address !== 1'b0) begin
      failures++;
      $display("FAIL stall_addr w1=%b w0=%b s_addr=%b exp w1=1 w0=0 s_addr=0", m1_waitrequest, m0_waitrequest, s_address);
    end
    cycle();
    m0_read = 1'b0;
    #1;
    checks++;
    if (m1_waitrequest !== 1'b0 || s_address !== 1'b1) begin
      failures++;
      $display("FAIL stall_release w1=%b s_addr=%b exp w1=0 s_addr=1", m1_waitrequest, s_address);
    end
    cycle();
    m1_read = 1'b0;
    checks++;
    if (m1_readdatavalid !== 1'b1 || m1_readdata !== TS_WORD) begin
      failures++;
      $display("FAIL stall_data v1=%b data=%h exp v1=1 data=%h", m1_readdatavalid, m1_readdata, TS_WORD);
    end
    cycle();
    $display("test_stalled_address done");
  endtask

  task automatic test_reset_mid();
    m0_read = 1'b1;
    m0_address = 1'b1;
    cycle();
    m0_read = 1'b0;
    checks++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== TS_WORD) begin
      failures++;
      $display("FAIL mid_pre v0=%b data=%h exp v0=1 data=%h", m0_readdatavalid, m0_readdata, TS_WORD);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (m0_readdatavalid !== 1'b0 || m0_readdata !== '0) begin
      failures++;
      $display("FAIL mid_async_clear v0=%b data=%h exp v0=0 data=0", m0_readdatavalid, m0_readdata);
    end
    cycle();
    reset_n = 1'b1;
    m0_read = 1'b1;
    m0_address = 1'b0;
    m1_read = 1'b1;
    m1_address = 1'b1;
    #1;
    checks++;
    if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
      failures++;
      $display("FAIL mid_first_grant w0=%b w1=%b exp w0=0 w1=1", m0_waitrequest, m1_waitrequest);
    end
    cycle();
    m0_read = 1'b0;
    m1_read = 1'b0;
    checks++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== ID_WORD) begin
      failures++;
      $display("FAIL mid_first_accept v0=%b data=%h exp v0=1 data=%h", m0_readdatavalid, m0_readdata, ID_WORD);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_idle();
    m1_read = 1'b1;
    m1_address = 1'b1;
    cycle();
    m1_read = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (s_address !== 1'b0 || m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b0 ||
          m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0 || m0_readdata !== TS_WORD) begin
        failures++;
        $display("FAIL idle[%0d] s_addr=%b w=%b%b v=%b%b data=%h exp s_addr=0 w=00 v=00 data=%h",
                 i, s_address, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, m0_readdata, TS_WORD);
      end
    end
    $display("test_idle done");
  endtask

  initial begin
    #2;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_contention();
    test_stalled_address();
    test_reset_mid();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
